strela_obi_mux: RTL and testbench



---
 rtl/strela_obi_mux_if.sv | 33 +++
 rtl/strela_obi_mux.sv | 67 ++++++
 tb/tb_strela_obi_mux.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/strela_obi_mux_if.sv
// strela_obi_mux_if: N upstream OBI ports and one merged downstream OBI master.
interface strela_obi_mux_if #(
  parameter int N_MASTERS = 8
);
  logic [N_MASTERS-1:0]       slaves_req;
  logic [N_MASTERS-1:0]       slaves_we;
  logic [N_MASTERS-1:0][3:0]  slaves_be;
  logic [N_MASTERS-1:0][31:0] slaves_addr;
  logic [N_MASTERS-1:0][31:0] slaves_wdata;
  logic [N_MASTERS-1:0]       slaves_gnt;
  logic [N_MASTERS-1:0]       slaves_rvalid;
  logic [N_MASTERS-1:0][31:0] slaves_rdata;
  logic                       master_req;
  logic                       master_we;
  logic [3:0]                 master_be;
  logic [31:0]                master_addr;
  logic [31:0]                master_wdata;
  logic                       master_gnt;
  logic                       master_rvalid;
  logic [31:0]                master_rdata;
  modport master (
    input  slaves_req, slaves_we, slaves_be, slaves_addr, slaves_wdata,
    input  master_gnt, master_rvalid, master_rdata,
    output slaves_gnt, slaves_rvalid, slaves_rdata,
    output master_req, master_we, master_be, master_addr, master_wdata
  );
  modport slave (
    output slaves_req, slaves_we, slaves_be, slaves_addr, slaves_wdata,
    output master_gnt, master_rvalid, master_rdata,
    input  slaves_gnt, slaves_rvalid, slaves_rdata,
    input  master_req, master_we, master_be, master_addr, master_wdata
  );
endinterface

// File: rtl/strela_obi_mux.sv
// strela_obi_mux: round-robin N-to-1 OBI mux with request lock and in-order response routing.
module strela_obi_mux #(
  parameter int N_MASTERS       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  strela_obi_mux_if.master   bus,
  output logic               err_o
);
  localparam int IW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING);
  logic [IW-1:0] rr_q, lock_idx_q, cand, sel, idx;
  logic          lock_q, any_req, full, fwd, hs, pop;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [CW-1:0] wr_q, rd_q;
  logic [CW:0]   cnt_q;
  // descending offsets so the lowest offset from rr_q wins
  always_comb begin
    cand = rr_q;
    idx  = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_q) + i) % N_MASTERS);
      if (bus.slaves_req[idx]) cand = idx;
    end
  end
  assign any_req = |bus.slaves_req;
  assign full    = cnt_q == (CW+1)'(MAX_OUTSTANDING);
  assign sel     = lock_q ? lock_idx_q : cand;
  assign fwd     = rst_ni & any_req & ~full;
  assign bus.master_req   = fwd & bus.slaves_req[sel];
  assign bus.master_we    = fwd & bus.slaves_we[sel];
  assign bus.master_be    = fwd ? bus.slaves_be[sel] : '0;
  assign bus.master_addr  = fwd ? bus.slaves_addr[sel] : '0;
  assign bus.master_wdata = fwd ? bus.slaves_wdata[sel] : '0;
  assign hs  = bus.master_req & bus.master_gnt;
  assign pop = rst_ni & bus.master_rvalid & (cnt_q != '0);
  assign bus.slaves_gnt    = hs ? N_MASTERS'(1) << sel : '0;
  assign bus.slaves_rvalid = pop ? N_MASTERS'(1) << fifo_q[rd_q] : '0;
  assign bus.slaves_rdata  = {N_MASTERS{bus.master_rdata}};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_o      <= 1'b0;
    end else begin
      if (hs) begin
        rr_q   <= sel == IW'(N_MASTERS - 1) ? '0 : sel + 1'b1;
        lock_q <= 1'b0;
        wr_q   <= wr_q + 1'b1;
      end else if (bus.master_req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (CW+1)'(hs) - (CW+1)'(pop);
      if (bus.master_rvalid && cnt_q == '0) err_o <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wr_q] <= sel;
  end
endmodule

// File: tb/tb_strela_obi_mux.sv
// tb_strela_obi_mux: directed scenarios plus random traffic against a queue-based reference model.
module tb_strela_obi_mux;
  localparam int N = 8;
  localparam int M = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic err;
  int   nchk, nbad, rr, lock, last_gnt;
  bit   m_err;
  int   q[$];
  strela_obi_mux_if #(.N_MASTERS(N)) bus ();
  strela_obi_mux #(.N_MASTERS(N), .MAX_OUTSTANDING(M)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.master), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic raise(input int p);
    logic [2:0] i;
    i = 3'(p);
    bus.slaves_req[i]   = 1'b1;
    bus.slaves_we[i]    = 1'($urandom);
    bus.slaves_be[i]    = 4'($urandom);
    bus.slaves_addr[i]  = $urandom;
    bus.slaves_wdata[i] = $urandom;
  endtask
  task automatic lower(input int p);
    logic [2:0] i;
    i = 3'(p);
    bus.slaves_req[i] = 1'b0;
  endtask
  // one clock: check combinational outputs against the model, then advance the model
  task automatic step();
    int sel;
    bit any, fwd, mreq;
    logic [2:0] si, hi;
    logic [127:0] ef;
    logic [N-1:0] eg, erv;
    #1;
    if (!rst_n) begin
      q.delete();
      rr = 0;
      lock = -1;
      m_err = 0;
    end
    any = rst_n && (bus.slaves_req != '0);
    sel = lock;
    if (lock < 0) begin
      sel = 0;
      for (int k = 0; k < N; k++)
        if (bus.slaves_req[3'((rr + k) % N)]) begin
          sel = (rr + k) % N;
          break;
        end
    end
    si = 3'(sel);
    hi = q.size() > 0 ? 3'(q[0]) : 3'd0;
    fwd = any && q.size() < M;
    mreq = fwd && bus.slaves_req[si];
    ef = fwd ? {59'd0, bus.slaves_we[si], bus.slaves_be[si], bus.slaves_addr[si], bus.slaves_wdata[si]} : '0;
    eg = (mreq && bus.master_gnt) ? N'(1) << si : '0;
    erv = (rst_n && bus.master_rvalid && q.size() > 0) ? N'(1) << hi : '0;
    check("mreq", bus.master_req, mreq);
    check("mfields", {59'd0, bus.master_we, bus.master_be, bus.master_addr, bus.master_wdata}, ef);
    check("gnt", bus.slaves_gnt, eg);
    check("rvalid", bus.slaves_rvalid, erv);
    if (erv != '0) check("rdata", bus.slaves_rdata[hi], bus.master_rdata);
    check("err", err, m_err);
    @(posedge clk);
    last_gnt = -1;
    if (rst_n) begin
      if (bus.master_rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (mreq && bus.master_gnt) begin
        q.push_back(sel);
        rr = (sel + 1) % N;
        lock = -1;
        last_gnt = sel;
      end else if (mreq) lock = sel;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.slaves_req = '0;
    bus.master_gnt = 1'b0;
    bus.master_rvalid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  task automatic drain();
    bus.master_gnt = 1'b0;
    for (int g = 0; g < 2 * M && q.size() > 0; g++) begin
      bus.master_rvalid = 1'b1;
      bus.master_rdata = $urandom;
      step();
    end
    bus.master_rvalid = 1'b0;
    check("drained", q.size(), 0);
  endtask
  initial begin
    int ord[$];
    int exp_ord[6] = '{0, 3, 7, 0, 3, 7};
    nchk = 0; nbad = 0; rr = 0; lock = -1; m_err = 0; last_gnt = -1;
    rst_n = 1'b0;
    bus.slaves_req = '0; bus.slaves_we = '0; bus.slaves_be = '0;
    bus.slaves_addr = '0; bus.slaves_wdata = '0;
    bus.master_gnt = 1'b0; bus.master_rvalid = 1'b0; bus.master_rdata = '0;
    @(negedge clk);
    for (int p = 0; p < N; p++) raise(p);
    step();
    step();
    check("rst_req", bus.master_req, 0);
    check("rst_gnt", bus.slaves_gnt, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    #1 check("first_sel", bus.master_addr, bus.slaves_addr[0]);
    step();
    // fairness: ports 0,3,7 continuous, bus grants every cycle, reply next cycle
    do_reset();
    raise(0); raise(3); raise(7);
    bus.master_gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.master_rvalid = q.size() > 0;
      bus.master_rdata = q.size() > 0 ? 32'(32'hA0 + q[0]) : 32'd0;
      step();
      if (last_gnt >= 0) ord.push_back(last_gnt);
    end
    for (int i = 0; i < 6; i++) check("fair_order", i < ord.size() ? ord[i] : -1, exp_ord[i]);
    bus.slaves_req = '0;
    drain();
    // lock: port 2 stalls three cycles while port 1 joins
    do_reset();
    raise(2);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) raise(1);
      #1;
      check("lock_addr", bus.master_addr, bus.slaves_addr[2]);
      check("lock_wdata", bus.master_wdata, bus.slaves_wdata[2]);
      step();
    end
    bus.master_gnt = 1'b1;
    step();
    check("lock_first", last_gnt, 2);
    lower(2);
    step();
    check("lock_second", last_gnt, 1);
    lower(1);
    drain();
    // backpressure at MAX_OUTSTANDING
    do_reset();
    for (int p = 0; p < 5; p++) raise(p);
    bus.master_gnt = 1'b1;
    for (int c = 0; c < M; c++) begin
      step();
      check("full_fill", last_gnt, c);
      if (last_gnt >= 0) lower(last_gnt);
    end
    #1 check("full_mask", bus.master_req, 0);
    step();
    bus.master_rvalid = 1'b1;
    step();
    check("full_nopush", last_gnt, -1);
    bus.master_rvalid = 1'b0;
    step();
    check("full_resume", last_gnt, 4);
    lower(4);
    drain();
    // random traffic with concurrent push/pop
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (last_gnt >= 0) lower(last_gnt);
      for (int p = 0; p < N; p++)
        if (!bus.slaves_req[3'(p)] && $urandom_range(0, 2) == 0) raise(p);
      bus.master_gnt = 1'($urandom);
      bus.master_rvalid = q.size() > 0 && $urandom_range(0, 1) == 1;
      bus.master_rdata = $urandom;
      step();
    end
    // reset mid-transaction, then a stray response
    do_reset();
    bus.master_rvalid = 1'b1;
    step();
    bus.master_rvalid = 1'b0;
    check("err_set", err, 1);
    repeat (5) step();
    check("err_sticky", err, 1);
    rst_n = 1'b0;
    step();
    check("err_clear", err, 0);
    rst_n = 1'b1;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
    $finish;
  end
endmodule
